// File: rtl/lab4_sys_dual_port_mem_responder_pkg.sv
// Shared message types and port tags for the dual-port memory responder.
// The request/response layouts follow the 16-byte line messages used by the
// system's imem/dmem streams: type, opaque, addr, len, data.
package lab4_sys_dual_port_mem_responder_pkg;

    typedef enum logic [2:0] {
        MEM_READ     = 3'd0,
        MEM_WRITE    = 3'd1,
        MEM_INIT     = 3'd2,
        MEM_AMO_ADD  = 3'd3,
        MEM_AMO_AND  = 3'd4,
        MEM_AMO_OR   = 3'd5,
        MEM_AMO_SWAP = 3'd6,
        MEM_AMO_MIN  = 3'd7
    } mem_type_e;

    typedef struct packed {
        mem_type_e    type_;
        logic [7:0]   opaque;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_req_16B_t;

    typedef struct packed {
        mem_type_e    type_;
        logic [7:0]   opaque;
        logic [1:0]   test;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_resp_16B_t;

    // Tag carried alongside each in-flight response to route it home.
    typedef enum logic {
        PORT_IMEM = 1'b0,
        PORT_DMEM = 1'b1
    } mem_port_e;

endpackage

// File: rtl/lab4_sys_mem_resp_queue.sv
// Per-port response FIFO. When empty, an arriving response is presented
// straight to the output so a ready consumer sees it without an extra cycle.
module lab4_sys_mem_resp_queue
    import lab4_sys_dual_port_mem_responder_pkg::*;
#(
    parameter int p_depth = 4
)(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          enq_val_i,
    input  mem_resp_16B_t enq_msg_i,
    output logic          enq_rdy_o,
    output logic          deq_val_o,
    output mem_resp_16B_t deq_msg_o,
    input  logic          deq_rdy_i
);

    localparam int c_ptr_nbits = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int c_cnt_nbits = $clog2(p_depth + 1);
    localparam logic [c_ptr_nbits-1:0] c_ptr_last = c_ptr_nbits'(p_depth - 1);
    localparam logic [c_ptr_nbits-1:0] c_ptr_one  = c_ptr_nbits'(1);
    localparam logic [c_cnt_nbits-1:0] c_cnt_full = c_cnt_nbits'(p_depth);
    localparam logic [c_cnt_nbits-1:0] c_cnt_one  = c_cnt_nbits'(1);

    mem_resp_16B_t          entries_q [p_depth];
    logic [c_ptr_nbits-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_nbits-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_nbits-1:0] count_q, count_d;
    logic                   empty;
    logic                   bypass;
    logic                   do_enq;
    logic                   do_deq;

    // Handshake decode, output selection and next pointer/count values.
    always_comb begin
        empty     = (count_q == '0);
        bypass    = empty && enq_val_i && deq_rdy_i;
        do_enq    = enq_val_i && !bypass;
        do_deq    = !empty && deq_rdy_i;
        enq_rdy_o = (count_q < c_cnt_full);
        deq_val_o = !empty || enq_val_i;
        deq_msg_o = empty ? enq_msg_i : entries_q[rd_ptr_q];

        wr_ptr_d = wr_ptr_q;
        if (do_enq) begin
            wr_ptr_d = (wr_ptr_q == c_ptr_last) ? '0 : wr_ptr_q + c_ptr_one;
        end

        rd_ptr_d = rd_ptr_q;
        if (do_deq) begin
            rd_ptr_d = (rd_ptr_q == c_ptr_last) ? '0 : rd_ptr_q + c_ptr_one;
        end

        count_d = count_q;
        if (do_enq && !do_deq) begin
            count_d = count_q + c_cnt_one;
        end else if (!do_enq && do_deq) begin
            count_d = count_q - c_cnt_one;
        end
    end

    // Pointer and occupancy registers; reset empties the queue.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset; only slots covered by count are visible.
    always_ff @(posedge clk_i) begin
        if (do_enq) begin
            entries_q[wr_ptr_q] <= enq_msg_i;
        end
    end

endmodule

// File: rtl/lab4_sys_dual_port_mem_responder.sv
// Two-port line memory responder: round-robin arbitration of imem/dmem
// requests into one line array, a fixed-latency tagged pipe, and a
// credit-limited response queue per port.
module lab4_sys_dual_port_mem_responder
    import lab4_sys_dual_port_mem_responder_pkg::*;
#(
    parameter int p_num_lines  = 256,
    parameter int p_latency    = 2,
    parameter int p_resp_depth = 4
)(
    input  logic          clk,
    input  logic          reset,
    input  mem_req_16B_t  imem_reqstream_msg,
    input  logic          imem_reqstream_val,
    output logic          imem_reqstream_rdy,
    output mem_resp_16B_t imem_respstream_msg,
    output logic          imem_respstream_val,
    input  logic          imem_respstream_rdy,
    input  mem_req_16B_t  dmem_reqstream_msg,
    input  logic          dmem_reqstream_val,
    output logic          dmem_reqstream_rdy,
    output mem_resp_16B_t dmem_respstream_msg,
    output logic          dmem_respstream_val,
    input  logic          dmem_respstream_rdy
);

    localparam int c_idx_nbits = $clog2(p_num_lines);
    localparam int c_cnt_nbits = $clog2(p_resp_depth + 1);
    localparam logic [c_cnt_nbits-1:0] c_cnt_max = c_cnt_nbits'(p_resp_depth);
    localparam logic [c_cnt_nbits-1:0] c_cnt_one = c_cnt_nbits'(1);

    logic [127:0]           mem_q [p_num_lines];

    logic                   pipe_val_q  [p_latency];
    mem_port_e              pipe_port_q [p_latency];
    mem_resp_16B_t          pipe_msg_q  [p_latency];

    logic [c_cnt_nbits-1:0] imem_cnt_q, imem_cnt_d;
    logic [c_cnt_nbits-1:0] dmem_cnt_q, dmem_cnt_d;
    mem_port_e              prio_q, prio_d;

    logic                   imem_elig, dmem_elig;
    logic                   grant_imem, grant_dmem, accept;
    logic                   imem_enq_val, dmem_enq_val;
    logic                   imem_enq_rdy, dmem_enq_rdy;
    logic                   imem_fire, dmem_fire;
    logic                   is_write;
    mem_req_16B_t           req_sel;
    mem_resp_16B_t          resp_new;
    logic [c_idx_nbits-1:0] idx;

    // Round-robin grant between eligible ports; nothing is granted in reset.
    always_comb begin
        imem_elig  = reset && imem_reqstream_val && (imem_cnt_q < c_cnt_max) && imem_enq_rdy;
        dmem_elig  = reset && dmem_reqstream_val && (dmem_cnt_q < c_cnt_max) && dmem_enq_rdy;
        grant_imem = 1'b0;
        grant_dmem = 1'b0;
        if (imem_elig && dmem_elig) begin
            if (prio_q == PORT_IMEM) begin
                grant_imem = 1'b1;
            end else begin
                grant_dmem = 1'b1;
            end
        end else begin
            grant_imem = imem_elig;
            grant_dmem = dmem_elig;
        end
        accept             = grant_imem || grant_dmem;
        imem_reqstream_rdy = grant_imem;
        dmem_reqstream_rdy = grant_dmem;
        prio_d             = prio_q;
        if (accept) begin
            prio_d = grant_imem ? PORT_DMEM : PORT_IMEM;
        end
    end

    // Build the response for the granted request from the array contents.
    always_comb begin
        req_sel         = grant_dmem ? dmem_reqstream_msg : imem_reqstream_msg;
        idx             = req_sel.addr[4 +: c_idx_nbits];
        is_write        = (req_sel.type_ == MEM_WRITE) || (req_sel.type_ == MEM_INIT);
        resp_new        = '0;
        resp_new.type_  = req_sel.type_;
        resp_new.opaque = req_sel.opaque;
        if (req_sel.type_ == MEM_READ) begin
            resp_new.data = mem_q[idx];
        end
    end

    // Array writes land on the accept edge; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (accept && is_write) begin
            mem_q[idx] <= req_sel.data;
        end
    end

    // Tagged delay pipe from accept to the per-port response queues.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < p_latency; i++) begin
                pipe_val_q[i]  <= 1'b0;
                pipe_port_q[i] <= PORT_IMEM;
                pipe_msg_q[i]  <= '0;
            end
        end else begin
            pipe_val_q[0]  <= accept;
            pipe_port_q[0] <= grant_dmem ? PORT_DMEM : PORT_IMEM;
            pipe_msg_q[0]  <= resp_new;
            for (int i = 1; i < p_latency; i++) begin
                pipe_val_q[i]  <= pipe_val_q[i-1];
                pipe_port_q[i] <= pipe_port_q[i-1];
                pipe_msg_q[i]  <= pipe_msg_q[i-1];
            end
        end
    end

    // Credit counters: up on accept, down on response handshake.
    always_comb begin
        imem_enq_val = pipe_val_q[p_latency-1] && (pipe_port_q[p_latency-1] == PORT_IMEM);
        dmem_enq_val = pipe_val_q[p_latency-1] && (pipe_port_q[p_latency-1] == PORT_DMEM);
        imem_fire    = imem_respstream_val && imem_respstream_rdy;
        dmem_fire    = dmem_respstream_val && dmem_respstream_rdy;
        imem_cnt_d   = imem_cnt_q;
        if (grant_imem && !imem_fire) begin
            imem_cnt_d = imem_cnt_q + c_cnt_one;
        end else if (!grant_imem && imem_fire) begin
            imem_cnt_d = imem_cnt_q - c_cnt_one;
        end
        dmem_cnt_d = dmem_cnt_q;
        if (grant_dmem && !dmem_fire) begin
            dmem_cnt_d = dmem_cnt_q + c_cnt_one;
        end else if (!grant_dmem && dmem_fire) begin
            dmem_cnt_d = dmem_cnt_q - c_cnt_one;
        end
    end

    // Credit and priority registers; reset restores imem priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imem_cnt_q <= '0;
            dmem_cnt_q <= '0;
            prio_q     <= PORT_IMEM;
        end else begin
            imem_cnt_q <= imem_cnt_d;
            dmem_cnt_q <= dmem_cnt_d;
            prio_q     <= prio_d;
        end
    end

    lab4_sys_mem_resp_queue #(.p_depth(p_resp_depth)) u_imem_queue (
        .clk_i     (clk),
        .rst_ni    (reset),
        .enq_val_i (imem_enq_val),
        .enq_msg_i (pipe_msg_q[p_latency-1]),
        .enq_rdy_o (imem_enq_rdy),
        .deq_val_o (imem_respstream_val),
        .deq_msg_o (imem_respstream_msg),
        .deq_rdy_i (imem_respstream_rdy)
    );

    lab4_sys_mem_resp_queue #(.p_depth(p_resp_depth)) u_dmem_queue (
        .clk_i     (clk),
        .rst_ni    (reset),
        .enq_val_i (dmem_enq_val),
        .enq_msg_i (pipe_msg_q[p_latency-1]),
        .enq_rdy_o (dmem_enq_rdy),
        .deq_val_o (dmem_respstream_val),
        .deq_msg_o (dmem_respstream_msg),
        .deq_rdy_i (dmem_respstream_rdy)
    );

endmodule

// File: tb/tb_lab4_sys_dual_port_mem_responder.sv
// Self-checking bench for the dual-port memory responder: a vector table of
// single requests, then hand-written contention, back-pressure and reset runs.
module tb_lab4_sys_dual_port_mem_responder;
    import lab4_sys_dual_port_mem_responder_pkg::*;

    localparam int L = 2;
    localparam int D = 4;

    localparam logic [127:0] dataA = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] dataB = 128'hDEADBEEF00112233CAFEF00D44556677;
    localparam logic [127:0] dataC = 128'h1111222233334444555566667777AAAA;
    localparam logic [127:0] dataD = 128'hA5A5A5A55A5A5A5AF0F0F0F00F0F0F0F;
    localparam logic [127:0] dataE = 128'h0000000100000002000000030000FFFF;

    logic          clk;
    logic          reset;
    mem_req_16B_t  imem_reqstream_msg;
    logic          imem_reqstream_val;
    logic          imem_reqstream_rdy;
    mem_resp_16B_t imem_respstream_msg;
    logic          imem_respstream_val;
    logic          imem_respstream_rdy;
    mem_req_16B_t  dmem_reqstream_msg;
    logic          dmem_reqstream_val;
    logic          dmem_reqstream_rdy;
    mem_resp_16B_t dmem_respstream_msg;
    logic          dmem_respstream_val;
    logic          dmem_respstream_rdy;

    typedef struct {
        mem_resp_16B_t resp;
        bit            lat;
    } sbEntry_t;

    typedef struct {
        mem_port_e    port;
        mem_type_e    typ;
        logic [7:0]   opaque;
        logic [31:0]  addr;
        logic [127:0] data;
        logic [127:0] expData;
    } vec_t;

    sbEntry_t imemSb [$];
    sbEntry_t dmemSb [$];
    int       imemAcc [$];
    int       dmemAcc [$];
    vec_t     vecs [10];

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    lab4_sys_dual_port_mem_responder #(
        .p_num_lines (256),
        .p_latency   (L),
        .p_resp_depth(D)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .imem_reqstream_msg (imem_reqstream_msg),
        .imem_reqstream_val (imem_reqstream_val),
        .imem_reqstream_rdy (imem_reqstream_rdy),
        .imem_respstream_msg(imem_respstream_msg),
        .imem_respstream_val(imem_respstream_val),
        .imem_respstream_rdy(imem_respstream_rdy),
        .dmem_reqstream_msg (dmem_reqstream_msg),
        .dmem_reqstream_val (dmem_reqstream_val),
        .dmem_reqstream_rdy (dmem_reqstream_rdy),
        .dmem_respstream_msg(dmem_respstream_msg),
        .dmem_respstream_val(dmem_respstream_val),
        .dmem_respstream_rdy(dmem_respstream_rdy)
    );

    // Free-running clock and cycle counter used for latency checks.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic mem_req_16B_t mkReq(input mem_type_e t, input logic [7:0] op,
                                           input logic [31:0] a, input logic [127:0] d);
        mem_req_16B_t r;
        r.type_  = t;
        r.opaque = op;
        r.addr   = a;
        r.len    = 4'd0;
        r.data   = d;
        return r;
    endfunction

    function automatic mem_resp_16B_t mkResp(input mem_type_e t, input logic [7:0] op,
                                             input logic [127:0] d);
        mem_resp_16B_t r;
        r.type_  = t;
        r.opaque = op;
        r.test   = 2'b00;
        r.len    = 4'd0;
        r.data   = d;
        return r;
    endfunction

    task automatic pushExp(input mem_port_e p, input mem_resp_16B_t r, input bit lat);
        sbEntry_t e;
        e.resp = r;
        e.lat  = lat;
        if (p == PORT_IMEM) imemSb.push_back(e);
        else dmemSb.push_back(e);
    endtask

    task automatic driveReq(input mem_port_e p, input mem_req_16B_t r);
        if (p == PORT_IMEM) begin
            imem_reqstream_msg = r;
            imem_reqstream_val = 1'b1;
        end else begin
            dmem_reqstream_msg = r;
            dmem_reqstream_val = 1'b1;
        end
    endtask

    task automatic dropReq(input mem_port_e p);
        if (p == PORT_IMEM) imem_reqstream_val = 1'b0;
        else dmem_reqstream_val = 1'b0;
    endtask

    // Compare one delivered response against the head of that port's scoreboard.
    task automatic checkOutput(input mem_port_e p, input mem_resp_16B_t msg);
        sbEntry_t e;
        int       acc;
        string    pn;
        pn = (p == PORT_IMEM) ? "imem" : "dmem";
        if ((p == PORT_IMEM && imemSb.size() == 0) || (p == PORT_DMEM && dmemSb.size() == 0)) begin
            total++;
            $display("[TB] FAIL %s unexpected resp: got %0h expected none", pn, msg);
        end else begin
            if (p == PORT_IMEM) begin
                e   = imemSb.pop_front();
                acc = (imemAcc.size() != 0) ? imemAcc.pop_front() : -1000;
            end else begin
                e   = dmemSb.pop_front();
                acc = (dmemAcc.size() != 0) ? dmemAcc.pop_front() : -1000;
            end
            checkVal($sformatf("%s resp op %0h", pn, e.resp.opaque), msg, e.resp);
            if (e.lat) checkVal($sformatf("%s latency op %0h", pn, e.resp.opaque), cyc - acc, L);
        end
    endtask

    // Monitor: records accepts and checks response handshakes mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            if (imem_reqstream_val && imem_reqstream_rdy) imemAcc.push_back(cyc);
            if (dmem_reqstream_val && dmem_reqstream_rdy) dmemAcc.push_back(cyc);
            if (imem_respstream_val && imem_respstream_rdy) checkOutput(PORT_IMEM, imem_respstream_msg);
            if (dmem_respstream_val && dmem_respstream_rdy) checkOutput(PORT_DMEM, dmem_respstream_msg);
        end
    end

    // Issue one table request, wait (bounded) for its accept, then release it.
    task automatic applyStimulus(input vec_t v, input bit lat);
        bit got;
        got = 1'b0;
        pushExp(v.port, mkResp(v.typ, v.opaque, v.expData), lat);
        driveReq(v.port, mkReq(v.typ, v.opaque, v.addr, v.data));
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (v.port == PORT_IMEM && imem_reqstream_val && imem_reqstream_rdy) got = 1'b1;
            if (v.port == PORT_DMEM && dmem_reqstream_val && dmem_reqstream_rdy) got = 1'b1;
            if (got) break;
        end
        @(posedge clk);
        #1;
        dropReq(v.port);
        checkVal($sformatf("accept op %0h", v.opaque), got, 1);
    endtask

    initial begin
        bit dGo, iGo, got;
        int dAcc, iAcc, cnt;

        vecs[0] = '{PORT_DMEM, MEM_INIT,    8'h05, 32'h0000_1000, dataA,   128'h0};
        vecs[1] = '{PORT_IMEM, MEM_READ,    8'h11, 32'h0000_1000, 128'h0,  dataA};
        vecs[2] = '{PORT_DMEM, MEM_WRITE,   8'h06, 32'h0000_0000, dataB,   128'h0};
        vecs[3] = '{PORT_IMEM, MEM_READ,    8'h12, 32'h0000_1000, 128'h0,  dataB};
        vecs[4] = '{PORT_DMEM, MEM_INIT,    8'h07, 32'h0000_0030, dataC,   128'h0};
        vecs[5] = '{PORT_IMEM, MEM_AMO_ADD, 8'h0B, 32'h0000_0030, 128'h5,  128'h0};
        vecs[6] = '{PORT_DMEM, MEM_READ,    8'h08, 32'h0000_0038, 128'h0,  dataC};
        vecs[7] = '{PORT_IMEM, MEM_WRITE,   8'h09, 32'h0000_0FF0, dataD,   128'h0};
        vecs[8] = '{PORT_IMEM, MEM_READ,    8'h0C, 32'h0000_0030, 128'h0,  dataC};
        vecs[9] = '{PORT_DMEM, MEM_READ,    8'h0A, 32'h0000_1FF0, 128'h0,  dataD};

        reset               = 1'b0;
        imem_reqstream_msg  = '0;
        dmem_reqstream_msg  = '0;
        imem_reqstream_val  = 1'b1;
        dmem_reqstream_val  = 1'b1;
        imem_respstream_rdy = 1'b1;
        dmem_respstream_rdy = 1'b1;

        #12;
        checkVal("reset imem req_rdy", imem_reqstream_rdy, 0);
        checkVal("reset dmem req_rdy", dmem_reqstream_rdy, 0);
        checkVal("reset imem resp_val", imem_respstream_val, 0);
        checkVal("reset dmem resp_val", dmem_respstream_val, 0);
        imem_reqstream_val = 1'b0;
        dmem_reqstream_val = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] table vectors");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], 1'b1);
            repeat (L + 2) @(posedge clk);
            #1;
        end

        $display("[TB] simultaneous reads");
        pushExp(PORT_IMEM, mkResp(MEM_READ, 8'h20, dataC), 1'b1);
        pushExp(PORT_DMEM, mkResp(MEM_READ, 8'h21, dataD), 1'b1);
        driveReq(PORT_IMEM, mkReq(MEM_READ, 8'h20, 32'h0000_0030, 128'h0));
        driveReq(PORT_DMEM, mkReq(MEM_READ, 8'h21, 32'h0000_0FF0, 128'h0));
        @(negedge clk);
        checkVal("simul cycle0 imem rdy", imem_reqstream_rdy, 1);
        checkVal("simul cycle0 dmem rdy", dmem_reqstream_rdy, 0);
        @(posedge clk);
        #1;
        dropReq(PORT_IMEM);
        @(negedge clk);
        checkVal("simul cycle1 dmem rdy", dmem_reqstream_rdy, 1);
        @(posedge clk);
        #1;
        dropReq(PORT_DMEM);
        repeat (L + 3) @(posedge clk);
        #1;

        $display("[TB] back-pressure");
        dmem_respstream_rdy = 1'b0;
        dAcc = 0;
        iAcc = 0;
        pushExp(PORT_DMEM, mkResp(MEM_READ, 8'h30, dataC), 1'b0);
        driveReq(PORT_DMEM, mkReq(MEM_READ, 8'h30, 32'h0000_0030, 128'h0));
        pushExp(PORT_IMEM, mkResp(MEM_READ, 8'h40, dataD), 1'b1);
        driveReq(PORT_IMEM, mkReq(MEM_READ, 8'h40, 32'h0000_0FF0, 128'h0));
        for (int c = 0; c < 32; c++) begin
            if (c == 16) begin
                checkVal("bp dmem accepts", dAcc, 4);
                checkVal("bp dmem req_rdy low", dmem_reqstream_rdy, 0);
                checkVal("bp imem accepts", iAcc, 6);
                dmem_respstream_rdy = 1'b1;
            end
            @(negedge clk);
            dGo = dmem_reqstream_val && dmem_reqstream_rdy;
            iGo = imem_reqstream_val && imem_reqstream_rdy;
            @(posedge clk);
            #1;
            if (dGo) begin
                dAcc++;
                if (dAcc < 6) begin
                    pushExp(PORT_DMEM, mkResp(MEM_READ, 8'(8'h30 + dAcc), dataC), 1'b0);
                    driveReq(PORT_DMEM, mkReq(MEM_READ, 8'(8'h30 + dAcc), 32'h0000_0030, 128'h0));
                end else begin
                    dropReq(PORT_DMEM);
                end
            end
            if (iGo) begin
                iAcc++;
                if (iAcc < 6) begin
                    pushExp(PORT_IMEM, mkResp(MEM_READ, 8'(8'h40 + iAcc), dataD), 1'b1);
                    driveReq(PORT_IMEM, mkReq(MEM_READ, 8'(8'h40 + iAcc), 32'h0000_0FF0, 128'h0));
                end else begin
                    dropReq(PORT_IMEM);
                end
            end
        end
        checkVal("bp dmem accepts after drain", dAcc, 6);
        dropReq(PORT_DMEM);
        dropReq(PORT_IMEM);
        repeat (L + D + 6) @(posedge clk);
        #1;

        $display("[TB] reset mid-flight");
        applyStimulus('{PORT_IMEM, MEM_WRITE, 8'h50, 32'h0000_0050, dataE, 128'h0}, 1'b1);
        repeat (L + 2) @(posedge clk);
        #1;
        driveReq(PORT_IMEM, mkReq(MEM_READ, 8'h51, 32'h0000_0050, 128'h0));
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (imem_reqstream_val && imem_reqstream_rdy) got = 1'b1;
            if (got) break;
        end
        @(posedge clk);
        #1;
        dropReq(PORT_IMEM);
        checkVal("reset test accept", got, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkVal("imem resp_val in reset", imem_respstream_val, 0);
        checkVal("dmem resp_val in reset", dmem_respstream_val, 0);
        repeat (2) @(posedge clk);
        imemAcc.delete();
        dmemAcc.delete();
        @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (imem_respstream_val) cnt++;
        end
        checkVal("no stale resp after reset", cnt, 0);
        @(posedge clk);
        #1;
        applyStimulus('{PORT_IMEM, MEM_READ, 8'h52, 32'h0000_0050, 128'h0, dataE}, 1'b1);
        repeat (L + D + 4) @(posedge clk);
        #1;

        checkVal("imem scoreboard drained", imemSb.size(), 0);
        checkVal("dmem scoreboard drained", dmemSb.size(), 0);

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
